// File: rtl/terminal_pkg.sv
// Shared definitions for the character terminal writer: geometry defaults,
// display-word layout, control codes and state encodings.
package terminal_pkg;

  localparam int ROWS_DEFAULT = 30;
  localparam int COLS_DEFAULT = 80;

  // Display word layout: {underline, fg[11:0], bg[11:0], char[7:0]}
  localparam int WD_W        = 33;
  localparam int ATTR_W      = 25;
  localparam int WD_CHAR_LSB = 0;
  localparam int WD_CHAR_MSB = 7;
  localparam int WD_BG_LSB   = 8;
  localparam int WD_BG_MSB   = 19;
  localparam int WD_FG_LSB   = 20;
  localparam int WD_FG_MSB   = 31;
  localparam int WD_UL_BIT   = 32;

  // Control codes and the blank fill character
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  // White on black, no underline
  localparam logic [ATTR_W-1:0] ATTR_RESET = {1'b0, 12'hFFF, 12'h000};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADVANCE,
    CUR_CR,
    CUR_LF,
    CUR_BS,
    CUR_HOME
  } cursor_op_t;

endpackage

// File: rtl/terminal_cursor.sv
// Cursor row/column counters. Flags when the current op moves to a new line
// so the writer can blank that line.
module terminal_cursor
  import terminal_pkg::*;
#(
  parameter int ROWS = ROWS_DEFAULT,
  parameter int COLS = COLS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  cursor_op_t op,
  output logic [4:0] row,
  output logic [6:0] col,
  output logic       new_line
);

  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);

  logic [4:0] row_next_line;

  assign row_next_line = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
  assign new_line      = (op == CUR_LF) || (op == CUR_ADVANCE && col == COL_LAST);

  // Apply one cursor operation per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register in the block sees the pre-edge values of the others.
      row <= 5'd0;
      col <= 7'd0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == COL_LAST) begin
            col <= 7'd0;
            row <= row_next_line;
          end else begin
            col <= col + 7'd1;
          end
        end
        CUR_CR:   col <= 7'd0;
        CUR_LF:   row <= row_next_line;
        CUR_BS:   if (col != 7'd0) col <= col - 7'd1;
        CUR_HOME: begin
          row <= 5'd0;
          col <= 7'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/terminal_writer.sv
// Turns a byte stream into display-buffer writes: prints characters at the
// cursor, interprets CR/LF/BS/FF, and blanks lines or the whole screen.
module terminal_writer
  import terminal_pkg::*;
#(
  parameter int ROWS           = ROWS_DEFAULT,
  parameter int COLS           = COLS_DEFAULT,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  output logic              in_ready,
  input  logic              attr_we,
  input  logic [ATTR_W-1:0] attr_in,
  output logic              we,
  output logic [4:0]        wr,
  output logic [6:0]        wc,
  output logic [WD_W-1:0]   wd,
  output logic [4:0]        cur_row,
  output logic [6:0]        cur_col,
  output logic              busy
);

  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);

  state_t            state;
  cursor_op_t        cur_op;
  logic              new_line;
  logic [ATTR_W-1:0] attr;
  logic [4:0]        clr_row;
  logic [6:0]        clr_col;
  logic              printable;
  logic              screen_last;

  assign in_ready    = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign printable   = (in_char >= CH_BLANK);
  assign screen_last = (clr_row == ROW_LAST) && (clr_col == COL_LAST);

  terminal_cursor #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .op       (cur_op),
    .row      (cur_row),
    .col      (cur_col),
    .new_line (new_line)
  );

  // Decode the cursor operation for this cycle
  always_comb begin
    // NOTE: default first so every path assigns cur_op and no latch forms.
    cur_op = CUR_HOLD;
    if (state == ST_IDLE && in_valid) begin
      if (printable) begin
        cur_op = CUR_ADVANCE;
      end else begin
        case (in_char)
          CH_CR:   cur_op = CUR_CR;
          CH_LF:   cur_op = CUR_LF;
          CH_BS:   cur_op = CUR_BS;
          default: cur_op = CUR_HOLD;
        endcase
      end
    end else if (state == ST_CLR_SCREEN && screen_last) begin
      cur_op = CUR_HOME;
    end
  end

  // Control state: FSM, clear counters, write strobe and attribute register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLR_SCREEN : ST_IDLE;
      we      <= 1'b0;
      clr_row <= 5'd0;
      clr_col <= 7'd0;
      attr    <= ATTR_RESET;
    end else begin
      we <= 1'b0;
      if (attr_we) attr <= attr_in;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            we      <= printable;
            clr_row <= 5'd0;
            clr_col <= 7'd0;
            if (new_line)              state <= ST_CLR_LINE;
            else if (in_char == CH_FF) state <= ST_CLR_SCREEN;
          end
        end
        ST_CLR_LINE: begin
          we <= 1'b1;
          if (clr_col == COL_LAST) state   <= ST_IDLE;
          else                     clr_col <= clr_col + 7'd1;
        end
        ST_CLR_SCREEN: begin
          we <= 1'b1;
          if (clr_col == COL_LAST) begin
            clr_col <= 7'd0;
            if (clr_row == ROW_LAST) state   <= ST_IDLE;
            else                     clr_row <= clr_row + 5'd1;
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write address/data path, qualified by we
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are only meaningful while we is high,
    // and we itself is reset.
    case (state)
      ST_CLR_LINE: begin
        wr <= cur_row;
        wc <= clr_col;
        wd <= {attr, CH_BLANK};
      end
      ST_CLR_SCREEN: begin
        wr <= clr_row;
        wc <= clr_col;
        wd <= {attr, CH_BLANK};
      end
      default: begin
        wr <= cur_row;
        wc <= cur_col;
        wd <= {attr, in_char};
      end
    endcase
  end

endmodule

// File: doc/terminal_writer.md
TERMINAL_WRITER -- requirements
Module: terminal_writer

Interface
REQ-001 SHALL have parameter ROWS, default 30, display rows.
REQ-002 SHALL have parameter COLS, default 80, display columns.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, a full-screen clear runs after reset.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports (name  direction  width  meaning):
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  in_valid  in  1  character byte offered
  in_char  in  8  character byte
  in_ready  out  1  byte accepted when in_valid&in_ready at posedge
  attr_we  in  1  load attribute register
  attr_in  in  25  {underline, fg[11:0], bg[11:0]}
  we  out  1  display buffer write strobe
  wr  out  5  write row
  wc  out  7  write col
  wd  out  33  {underline, fg[11:0], bg[11:0], char[7:0]}
  cur_row  out  5  cursor row
  cur_col  out  7  cursor col
  busy  out  1  clear in progress

Function
REQ-006 SHALL implement states IDLE, CLR_LINE and CLR_SCREEN; in_ready = 1 only in IDLE.
REQ-007 Printable byte (>= 0x20) accepted at cycle N SHALL produce we=1 at N+1 with wr/wc = cursor at N and wd = {attr, byte}.
REQ-008 After a printable write, cursor SHALL advance to col+1; from col COLS-1 it SHALL advance to col 0 with a line feed (REQ-010).
REQ-009 0x0D (CR) SHALL set col=0; 0x08 (BS) SHALL decrement col if col>0 and SHALL NOT write; other bytes < 0x20 not listed SHALL be consumed with no write and no cursor change.
REQ-010 0x0A (LF) SHALL increment row; from row ROWS-1 it SHALL wrap to row 0. The new row SHALL then be cleared via CLR_LINE.
REQ-011 CLR_LINE SHALL write COLS cells of the target row, one per cycle, cols 0..COLS-1, with wd = {attr, 8'h20}. It SHALL then return to IDLE.
REQ-012 0x0C (FF) SHALL enter CLR_SCREEN, write ROWS*COLS cells one per cycle in row-major order with {attr, 8'h20}, then set cursor to (0,0) and return to IDLE.
REQ-013 busy SHALL equal (state != IDLE); we SHALL be 1 on every clear cycle.
REQ-014 attr_we SHALL load attr_in at the clock edge in any state. A byte accepted in the same cycle SHALL use the previous attribute. A clear in progress SHALL use the attribute current at each write cycle.
REQ-015 wr/wc/wd SHALL be registered outputs; when we=0 their values are don't-care.
REQ-016 cur_row/cur_col SHALL always lie within 0..ROWS-1 / 0..COLS-1.

Reset
REQ-017 Reset SHALL set cursor (0,0), we=0, and attribute {0, 12'hFFF, 12'h000}.
REQ-018 Reset SHALL enter CLR_SCREEN when CLEAR_ON_RESET=1 and IDLE otherwise.
REQ-019 Reset asserted mid-clear SHALL abort the clear; the outputs SHALL then follow REQ-017/018 from the next cycle.

Structure
REQ-020 Package terminal_pkg SHALL hold ROWS/COLS defaults, wd field bit positions, control-code constants (0x08, 0x0A, 0x0C, 0x0D), the blank character 0x20, and the state enum.
REQ-021 Sub-module terminal_cursor SHALL hold the row/col counters with ops {hold, advance, cr, lf, bs, home}. It SHALL report the wrap-to-new-line event.

Verification
REQ-022 Reset with CLEAR_ON_RESET=1: busy=1 and we=1 for exactly 2400 cycles, covering (0,0) through (29,79) with wd=0x0_FFF0_0020; then in_ready=1 and cursor (0,0).
REQ-023 Idle at (3,5); send 'A' (0x41) -> next cycle we=1, wr=3, wc=5, wd char=0x41; cursor becomes (3,6).
REQ-024 Cursor (29,79); send 'Z' -> write at (29,79); cursor becomes (0,0); 80 clear writes on row 0; in_ready low throughout.
REQ-025 Cursor (7,0); send 0x08 -> no write, cursor stays (7,0). Send 0x0D at (7,40) -> cursor (7,0).
REQ-026 Same cycle: attr_we with attr_in={1, 12'h0F0, 12'h00F} and 'B' accepted -> 'B' written with the old attribute; the next char is written with wd[32:8]={1, 0x0F0, 0x00F}.
REQ-027 Send 0x0C, then assert reset after 100 clear cycles, with CLEAR_ON_RESET=0 -> the cycle after reset we=0, cursor (0,0) and in_ready=1.
